// File: rtl/pipe_pkg.sv
// Shared pipeline-control definitions: FSM state encoding and the default
// memory-wait timeout used by pipe_ctrl.
package pipe_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LSTALL   = 2'd1,
    MEM_WAIT = 2'd2
  } pipe_state_e;

  localparam int MEM_TIMEOUT_DEF = 16;
  localparam int WAIT_W          = 8;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use hazard compare: a load in EX whose destination feeds either
// source of the instruction in ID. x0 never creates a hazard.
module hazard_detect (
  input  logic       ex_memread_i,
  input  logic [4:0] ex_rd_i,
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  output logic       hazard_o
);

  assign hazard_o = ex_memread_i && (ex_rd_i != 5'd0) &&
                    ((ex_rd_i == id_rs1_i) || (ex_rd_i == id_rs2_i));

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller (RUN / LSTALL / MEM_WAIT) with memory timeout.
// Define PIPE_CTRL_PERF_EN to build the stall_cycles / flush_count counters.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  ex_rd,
  input  logic        ex_memread,
  input  logic        branchtaken,
  input  logic        dmem_req,
  input  logic        dmem_ready,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        idex_en,
  output logic        exmem_en,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        memwb_bubble,
  output logic        mem_err,
  output logic [31:0] stall_cycles,
  output logic [15:0] flush_count
);

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  pipe_state_e       state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              mem_err_q, mem_err_d;
  logic              hazard, mem_stall;

  hazard_detect u_hazard (
    .ex_memread_i (ex_memread),
    .ex_rd_i      (ex_rd),
    .id_rs1_i     (id_rs1),
    .id_rs2_i     (id_rs2),
    .hazard_o     (hazard)
  );

  assign mem_stall = dmem_req && !dmem_ready;
  assign mem_err   = mem_err_q;

  always_comb begin
    pc_en        = 1'b1;
    ifid_en      = 1'b1;
    idex_en      = 1'b1;
    exmem_en     = 1'b1;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    memwb_bubble = 1'b0;
    state_d      = state_q;
    wait_d       = wait_q;
    mem_err_d    = mem_err_q;
    if (reset) begin
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      idex_en      = 1'b0;
      exmem_en     = 1'b0;
      ifid_flush   = 1'b1;
      idex_flush   = 1'b1;
      memwb_bubble = 1'b1;
      state_d      = RUN;
    end else begin
      case (state_q)
        MEM_WAIT: begin
          if (dmem_ready) begin
            state_d = RUN;
          end else if (wait_q == WAIT_LAST) begin
            // Give up: squash the access and let the pipe move on.
            memwb_bubble = 1'b1;
            mem_err_d    = 1'b1;
            state_d      = RUN;
          end else begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            idex_en      = 1'b0;
            exmem_en     = 1'b0;
            memwb_bubble = 1'b1;
            wait_d       = wait_q + 1'b1;
          end
        end
        default: begin
          // RUN and LSTALL share rules, except LSTALL ignores load-use.
          if (mem_stall) begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            idex_en      = 1'b0;
            exmem_en     = 1'b0;
            memwb_bubble = 1'b1;
            wait_d       = '0;
            state_d      = MEM_WAIT;
          end else if (branchtaken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            state_d    = RUN;
          end else if (state_q == RUN && hazard) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
            state_d    = LSTALL;
          end else begin
            state_d = RUN;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= RUN;
      wait_q    <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      mem_err_q <= mem_err_d;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_q;
  logic [15:0] flush_q;
  logic        flush_inc;

  assign flush_inc = (state_q != MEM_WAIT) && !mem_stall && branchtaken;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!pc_en && stall_q != '1) stall_q <= stall_q + 1'b1;
      if (flush_inc && flush_q != '1) flush_q <= flush_q + 1'b1;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL: MEM_TIMEOUT, 16, max MEM_WAIT cycles before abort (range 2..255).
REQ-002 SHALL: clock  in  1  rising-edge clock.
REQ-003 SHALL: reset  in  1  reset, asynchronous, active-high.
REQ-004 SHALL: id_rs1  in  5  source reg 1 of instruction in ID.
REQ-005 SHALL: id_rs2  in  5  source reg 2 of instruction in ID.
REQ-006 SHALL: ex_rd  in  5  destination reg of instruction in EX.
REQ-007 SHALL: ex_memread  in  1  instruction in EX is a load.
REQ-008 SHALL: branchtaken  in  1  branch resolved taken in EX.
REQ-009 SHALL: dmem_req  in  1  MEM stage issuing data-memory access.
REQ-010 SHALL: dmem_ready  in  1  data memory completes access this cycle.
REQ-011 SHALL: pc_en  out  1  PC update enable.
REQ-012 SHALL: ifid_en, idex_en, exmem_en  out  1 each  pipeline register load enables.
REQ-013 SHALL: ifid_flush, idex_flush  out  1 each  load bubble (all zero) into IF_ID / ID_EX.
REQ-014 SHALL: memwb_bubble  out  1  force RegWrite=0 into MEM_WB.
REQ-015 SHALL: mem_err  out  1  sticky memory-timeout flag.
REQ-016 SHALL: stall_cycles  out  32  stall cycle count (perf).
REQ-017 SHALL: flush_count  out  16  branch flush count (perf).

Function
REQ-018 SHALL: states RUN, LSTALL, MEM_WAIT; outputs combinational from state and inputs.
REQ-019 SHALL: defaults: all enables 1, flushes 0, memwb_bubble 0.
REQ-020 SHALL: load-use hazard = ex_memread & ex_rd!=0 & (ex_rd==id_rs1 | ex_rd==id_rs2).
REQ-021 SHALL: mem stall = dmem_req & !dmem_ready; priority mem stall > branchtaken > load-use.
REQ-022 SHALL: RUN + mem stall: pc_en=ifid_en=idex_en=exmem_en=0, memwb_bubble=1; next MEM_WAIT; wait counter cleared.
REQ-023 SHALL: RUN + branchtaken (no mem stall): ifid_flush=idex_flush=1, pc_en=1; stay RUN; flush_count+1.
REQ-024 SHALL: RUN + load-use (no mem stall, no branch): pc_en=ifid_en=0, idex_flush=1; next LSTALL.
REQ-025 SHALL: LSTALL: hazard detection suppressed, defaults driven unless mem stall/branch (same rules as RUN); next RUN; lasts exactly 1 cycle.
REQ-026 SHALL: MEM_WAIT + !dmem_ready: freeze as REQ-022; wait counter+1.
REQ-027 SHALL: MEM_WAIT + dmem_ready: defaults; next RUN; branch held in frozen EX is serviced on following RUN cycle.
REQ-028 SHALL: MEM_WAIT, counter==MEM_TIMEOUT-1, !dmem_ready: set mem_err, enables 1, memwb_bubble=1 (squash access), next RUN.
REQ-029 SHALL: dmem_ready with both dmem_req=0 and state RUN ignored.
REQ-030 SHALL: stall_cycles +1 every cycle pc_en=0; both counters saturate at all-ones.

Reset
REQ-031 SHALL: reset asynchronously forces state RUN, wait counter 0, mem_err 0, stall_cycles 0, flush_count 0.
REQ-032 SHALL: while reset high, all enables 0, flushes 1, memwb_bubble 1; reset mid-MEM_WAIT aborts wait without mem_err.

Configuration
REQ-033 SHALL: macro PIPE_CTRL_PERF_EN defined: stall_cycles/flush_count counters implemented per REQ-023/030.
REQ-034 SHALL: macro undefined: no counter flops; stall_cycles and flush_count tied to 0; ports retained.

Structure
REQ-035 SHALL: state enum (RUN, LSTALL, MEM_WAIT) and default MEM_TIMEOUT constant live in shared package pipe_pkg.
REQ-036 SHALL: hazard compare in sub-module hazard_detect (combinational); FSM, counters in pipe_ctrl.

Verification
REQ-037 SHALL: ex_memread=1, ex_rd=5, id_rs2=5 in RUN -> 1 cycle pc_en=0, idex_flush=1, then RUN, stall_cycles=1.
REQ-038 SHALL: ex_memread=1, ex_rd=0, id_rs1=0 -> no stall.
REQ-039 SHALL: branchtaken=1 with load-use hazard -> ifid_flush=idex_flush=1, pc_en=1, no LSTALL, flush_count=1.
REQ-040 SHALL: dmem_req=1, dmem_ready low 3 cycles then high -> 3 frozen cycles (memwb_bubble=1), release on 4th, mem_err=0.
REQ-041 SHALL: dmem_req=1, dmem_ready never high, MEM_TIMEOUT=16 -> mem_err=1 after 16 frozen cycles total, state RUN, mem_err held until reset.
REQ-042 SHALL: reset pulse during MEM_WAIT cycle 2 -> state RUN, counters 0, mem_err 0 immediately.
